// File: rtl/fft_pkg.sv
// Shared constants and types for the FIR-to-FFT block path.
// Sample width, block geometry and the two-state bank status used by the collector.
package fft_pkg;
  localparam int DW         = 16;
  localparam int N          = 16;
  localparam int FRAME_BLKS = 64;
  localparam int CW         = $clog2(N);
  localparam int IW         = $clog2(FRAME_BLKS);

  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;
endpackage

// File: rtl/s2p_bank.sv
// N-entry sample register bank: one slot written per enabled cycle, all slots read in parallel.
// Slot k appears at o_flat[k*DW +: DW].
module s2p_bank
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [CW-1:0]   i_slot,
  input  logic [DW-1:0]   i_d,
  output logic [N*DW-1:0] o_flat
);

  sample_t r_mem [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      r_mem[i_slot] <= i_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign o_flat[k*DW +: DW] = r_mem[k];
  end

endmodule

// File: rtl/fir_block_collector.sv
// Regroups the unstallable serial FIR stream into N-sample blocks using two ping-pong banks.
// Tracks block index within a frame and latches a sticky overflow when a sample is lost.
module fir_block_collector
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   fir_d,
  input  logic            fir_valid,
  output logic [N*DW-1:0] blk_data,
  output logic            blk_valid,
  input  logic            blk_ready,
  output logic            blk_last,
  output logic [IW-1:0]   blk_idx,
  output logic            overflow
);

  bank_state_t     r_state [2];
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [CW-1:0]   r_wr_cnt;
  logic [IW-1:0]   r_blk_idx;
  logic            r_overflow;

  logic            w_wr_full;
  logic            w_wr_en;
  logic            w_wr_last;
  logic            w_rd_full;
  logic            w_hs;
  logic [N*DW-1:0] w_flat0;
  logic [N*DW-1:0] w_flat1;

  // Writes only ever land in an EMPTY bank, so the presented FULL bank stays stable.
  assign w_wr_full = (r_state[r_wr_bank] == FULL);
  assign w_wr_en   = fir_valid & ~w_wr_full;
  assign w_wr_last = w_wr_en & (r_wr_cnt == CW'(N-1));
  assign w_rd_full = (r_state[r_rd_bank] == FULL);
  assign w_hs      = w_rd_full & blk_ready;

  s2p_bank u_bank0 (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_wr_en & ~r_wr_bank),
    .i_slot (r_wr_cnt),
    .i_d    (fir_d),
    .o_flat (w_flat0)
  );

  s2p_bank u_bank1 (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_wr_en & r_wr_bank),
    .i_slot (r_wr_cnt),
    .i_d    (fir_d),
    .o_flat (w_flat1)
  );

  // A completing write and a handshake never target the same bank, so both apply together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_blk_idx  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        if (w_wr_last) begin
          r_wr_cnt           <= '0;
          r_state[r_wr_bank] <= FULL;
          r_wr_bank          <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
      if (fir_valid & w_wr_full) r_overflow <= 1'b1;
      if (w_hs) begin
        r_state[r_rd_bank] <= EMPTY;
        r_rd_bank          <= ~r_rd_bank;
        r_blk_idx          <= (r_blk_idx == IW'(FRAME_BLKS-1)) ? '0 : r_blk_idx + 1'b1;
      end
    end
  end

  assign blk_valid = w_rd_full;
  assign blk_data  = r_rd_bank ? w_flat1 : w_flat0;
  assign blk_last  = w_rd_full & (r_blk_idx == IW'(FRAME_BLKS-1));
  assign blk_idx   = r_blk_idx;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fir_block_collector.sv
// Bench for fir_block_collector: a two-block-capacity queue model predicts accepted samples,
// drops and delivered blocks; a negedge monitor scores every handshake against it.
module tb_fir_block_collector;
  import fft_pkg::*;

  logic            clk;
  logic            rst;
  logic [DW-1:0]   fir_d;
  logic            fir_valid;
  logic [N*DW-1:0] blk_data;
  logic            blk_valid;
  logic            blk_ready;
  logic            blk_last;
  logic [IW-1:0]   blk_idx;
  logic            overflow;

  typedef struct {
    logic [N*DW-1:0] data;
    int              idx;
  } exp_t;

  exp_t          expQ[$];
  logic [DW-1:0] mPart[$];
  int            mFull;
  int            mDone;
  bit            mOvf;
  int            errors;
  int            checks;
  bit            prevHold;
  logic [N*DW-1:0] prevData;

  fir_block_collector dut (
    .clk       (clk),
    .rst       (rst),
    .fir_d     (fir_d),
    .fir_valid (fir_valid),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_last  (blk_last),
    .blk_idx   (blk_idx),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [N*DW-1:0] act,
                             input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, then advance the model as the collector would at the edge.
  task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit rdy);
    bit hs;
    bit acc;
    logic [N*DW-1:0] blk;
    fir_valid = v;
    fir_d     = d;
    blk_ready = rdy;
    @(posedge clk);
    hs  = (mFull > 0) && rdy;
    acc = v && (mFull < 2);
    if (v && !acc) mOvf = 1'b1;
    if (hs) mFull--;
    if (acc) begin
      mPart.push_back(d);
      if (mPart.size() == N) begin
        blk = '0;
        for (int k = 0; k < N; k++) blk[k*DW +: DW] = mPart[k];
        expQ.push_back('{data: blk, idx: mDone % FRAME_BLKS});
        mDone++;
        mFull++;
        mPart.delete();
      end
    end
    #1;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    fir_valid = 1'b0;
    fir_d     = '0;
    blk_ready = 1'b0;
    mFull = 0;
    mDone = 0;
    mOvf  = 1'b0;
    mPart.delete();
    expQ.delete();
    #1;
    checkOutput("rst_blk_valid", N*DW'(blk_valid), '0);
    checkOutput("rst_blk_last", N*DW'(blk_last), '0);
    checkOutput("rst_blk_idx", N*DW'(blk_idx), '0);
    checkOutput("rst_overflow", N*DW'(overflow), '0);
    checkOutput("rst_blk_data", blk_data, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && mFull > 0; c++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("drain_pending", N*DW'(expQ.size()), '0);
  endtask

  // Monitor: scoreboard pop on every handshake plus per-cycle status and hold-stability checks.
  always @(negedge clk) begin
    if (rst) begin
      prevHold = 1'b0;
    end else begin
      checkOutput("blk_valid", N*DW'(blk_valid), N*DW'(mFull > 0));
      checkOutput("overflow", N*DW'(overflow), N*DW'(mOvf));
      if (prevHold && blk_valid) checkOutput("hold_stable", blk_data, prevData);
      if (blk_valid && blk_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_block", N*DW'(1), N*DW'(0));
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("blk_data", blk_data, e.data);
          checkOutput("blk_idx", N*DW'(blk_idx), N*DW'(e.idx));
          checkOutput("blk_last", N*DW'(blk_last), N*DW'(e.idx == FRAME_BLKS-1));
        end
      end
      prevHold = blk_valid && !blk_ready;
      prevData = blk_data;
    end
  end

  initial begin
    errors   = 0;
    checks   = 0;
    prevHold = 1'b0;
    prevData = '0;
    rst      = 1'b1;

    // Basic block of samples 1..16 with downstream always ready.
    doReset();
    for (int i = 1; i <= N; i++) applyStimulus(1'b1, DW'(i), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    drain();

    // Back-pressure: fill both banks, drop sample 33, then release in order.
    doReset();
    for (int i = 0; i < 2*N + 1; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);
    drain();

    // Full frame with random input gaps, then one extra block to see the index wrap.
    doReset();
    for (int i = 0; i < N*FRAME_BLKS + N; ) begin
      if ($urandom_range(3) != 0) begin
        applyStimulus(1'b1, DW'($urandom), 1'b1);
        i++;
      end else begin
        applyStimulus(1'b0, DW'($urandom), 1'b1);
      end
    end
    drain();

    // Half-rate input with randomly toggling ready.
    for (int i = 0; i < 30*N; i++) begin
      applyStimulus(1'b1, DW'($urandom), 1'($urandom_range(1)));
      applyStimulus(1'b0, DW'($urandom), 1'($urandom_range(1)));
    end
    drain();

    // Reset mid-block discards the partial block.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, DW'($urandom), 1'b1);
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(1'b1, DW'(16'h100 + i), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    drain();

    // Handshake on bank 1 in the same cycle bank 0 completes.
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < N; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < N-1; i++) applyStimulus(1'b1, DW'($urandom), 1'b0);
    applyStimulus(1'b1, DW'($urandom), 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
